// File: rtl/ecall_status_tx.sv
// Captures end-of-test status when an ecall retires in write-back and streams it
// to the host as a 7-byte frame (header, status, two 16-bit counters, XOR checksum).
module ecall_status_tx #(
    parameter int          CNT_W = 16,
    parameter logic [7:0]  HDR   = 8'hA5
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic             i_ecall_instr,
    input  logic             i_a0_reg_lsb,
    input  logic [3:0]       i_cause,
    input  logic [CNT_W-1:0] i_branch_total,
    input  logic [CNT_W-1:0] i_branch_mispred,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_halt,
    output logic             o_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [2:0]       r_idx;
    logic             r_a0;
    logic [3:0]       r_cause;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_mispred;
    logic [7:0]       r_csum;
    logic             r_halt;

    logic [7:0]       w_status_in;
    logic [7:0]       w_csum_in;
    logic [7:0]       w_byte;
    logic             w_accept;

    assign w_status_in = {3'b000, i_cause, i_a0_reg_lsb};
    // Checksum is taken from the same values that land in the snapshot, so it matches the frame.
    assign w_csum_in   = HDR ^ w_status_in
                       ^ i_branch_total[7:0]   ^ i_branch_total[15:8]
                       ^ i_branch_mispred[7:0] ^ i_branch_mispred[15:8];

    assign w_accept = (r_state == ST_SEND) && i_tx_ready;

    always_comb begin
        w_byte = '0;
        case (r_idx)
            3'd0:    w_byte = HDR;
            3'd1:    w_byte = {3'b000, r_cause, r_a0};
            3'd2:    w_byte = r_total[7:0];
            3'd3:    w_byte = r_total[15:8];
            3'd4:    w_byte = r_mispred[7:0];
            3'd5:    w_byte = r_mispred[15:8];
            3'd6:    w_byte = r_csum;
            default: w_byte = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_a0      <= 1'b0;
            r_cause   <= '0;
            r_total   <= '0;
            r_mispred <= '0;
            r_csum    <= '0;
            r_halt    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_ecall_instr) begin
                        r_a0      <= i_a0_reg_lsb;
                        r_cause   <= i_cause;
                        r_total   <= i_branch_total;
                        r_mispred <= i_branch_mispred;
                        r_csum    <= w_csum_in;
                        r_idx     <= '0;
                        r_halt    <= 1'b1;
                        r_state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (r_idx == 3'd6) begin
                            r_idx   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_DONE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    assign o_tx_valid = (r_state == ST_SEND);
    assign o_tx_data  = (r_state == ST_SEND) ? w_byte : '0;
    assign o_halt     = r_halt;
    assign o_done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_ecall_status_tx.sv
// Self-checking bench for ecall_status_tx: fixed frames, backpressure, snapshot
// isolation, mid-frame reset, idle quiet and randomized scoreboard runs.
module tb_ecall_status_tx;

    logic        clk;
    logic        arstn;
    logic        ecall;
    logic        a0;
    logic [3:0]  cause;
    logic [15:0] total;
    logic [15:0] mispred;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic        done;

    int n_tests;
    int n_fail;

    logic [7:0] exp_frame [7];

    ecall_status_tx #(.CNT_W(16), .HDR(8'hA5)) dut (
        .i_clk            (clk),
        .i_arstn          (arstn),
        .i_ecall_instr    (ecall),
        .i_a0_reg_lsb     (a0),
        .i_cause          (cause),
        .i_branch_total   (total),
        .i_branch_mispred (mispred),
        .o_tx_data        (tx_data),
        .o_tx_valid       (tx_valid),
        .i_tx_ready       (tx_ready),
        .o_halt           (halt),
        .o_done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame built straight from the byte layout; checksum is XOR of bytes 0..5.
    task automatic build_frame(input logic fa0, input logic [3:0] fc,
                               input logic [15:0] ft, input logic [15:0] fm);
        logic [7:0] x;
        exp_frame[0] = 8'hA5;
        exp_frame[1] = {3'b000, fc, fa0};
        exp_frame[2] = ft % 256;
        exp_frame[3] = ft / 256;
        exp_frame[4] = fm % 256;
        exp_frame[5] = fm / 256;
        x = 8'h00;
        for (int i = 0; i < 6; i++) x = x ^ exp_frame[i];
        exp_frame[6] = x;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        arstn = 1'b0;
        ecall = 1'b0;
        @(negedge clk);
        arstn = 1'b1;
    endtask

    // Returns at the negedge of cycle N+1, where b0 should be on the bus.
    task automatic do_ecall(input logic fa0, input logic [3:0] fc,
                            input logic [15:0] ft, input logic [15:0] fm);
        @(negedge clk);
        a0 = fa0; cause = fc; total = ft; mispred = fm;
        ecall = 1'b1;
        @(negedge clk);
        ecall = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        arstn = 1'b0;
        #1;
        n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", tx_valid); end
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", tx_data); end
        n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got=%b exp=0", halt); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clk);
        arstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] req [7];
        req = '{8'hA5, 8'h17, 8'h34, 8'h12, 8'h56, 8'h00, 8'hC2};
        apply_reset();
        tx_ready = 1'b1;
        do_ecall(1'b1, 4'hB, 16'h1234, 16'h0056);
        for (int k = 0; k < 7; k++) begin
            n_tests++; if (tx_valid !== 1'b1 || tx_data !== req[k]) begin
                n_fail++; $display("FAIL basic_b%0d got=%b/%h exp=1/%h", k, tx_valid, tx_data, req[k]);
            end
            n_tests++; if (halt !== 1'b1) begin n_fail++; $display("FAIL basic_halt_c%0d got=%b exp=1", k + 1, halt); end
            n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done_c%0d got=%b exp=0", k + 1, done); end
            @(negedge clk);
        end
        n_tests++; if (done !== 1'b1 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_n8 got=%b/%b exp=1/0", done, tx_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] req [7];
        int k, stall, cyc;
        req = '{8'hA5, 8'h17, 8'h34, 8'h12, 8'h56, 8'h00, 8'hC2};
        apply_reset();
        tx_ready = 1'b1;
        do_ecall(1'b1, 4'hB, 16'h1234, 16'h0056);
        k = 0; stall = 0; cyc = 1;
        while (k < 7 && cyc < 40) begin
            n_tests++; if (tx_valid !== 1'b1 || tx_data !== req[k]) begin
                n_fail++; $display("FAIL bp_c%0d got=%b/%h exp=1/%h", cyc, tx_valid, tx_data, req[k]);
            end
            if (k == 2 && stall < 3) begin
                tx_ready = 1'b0; stall++;
            end else begin
                tx_ready = 1'b1; k++;
            end
            @(negedge clk);
            cyc++;
        end
        n_tests++; if (cyc !== 11 || done !== 1'b1) begin
            n_fail++; $display("FAIL bp_done_cycle got=N+%0d done=%b exp=N+11 done=1", cyc, done);
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_isolation();
        apply_reset();
        tx_ready = 1'b1;
        build_frame(1'b1, 4'hB, 16'h1234, 16'h0056);
        do_ecall(1'b1, 4'hB, 16'h1234, 16'h0056);
        total = 16'hFFFF; mispred = 16'hBEEF; a0 = 1'b0; cause = 4'h3;
        for (int k = 0; k < 7; k++) begin
            n_tests++; if (tx_valid !== 1'b1 || tx_data !== exp_frame[k]) begin
                n_fail++; $display("FAIL iso_b%0d got=%b/%h exp=1/%h", k, tx_valid, tx_data, exp_frame[k]);
            end
            ecall = (k == 1 || k == 4);
            @(negedge clk);
        end
        ecall = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ecall = (c < 2);
            n_tests++; if (done !== 1'b1 || tx_valid !== 1'b0 || halt !== 1'b1) begin
                n_fail++; $display("FAIL iso_done_hold_c%0d got=%b/%b/%b exp=1/0/1", c, done, tx_valid, halt);
            end
        end
        ecall = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] req [7];
        req = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
        apply_reset();
        tx_ready = 1'b1;
        do_ecall(1'b1, 4'hB, 16'h1234, 16'h0056);
        for (int k = 0; k < 4; k++) @(negedge clk);
        #2 arstn = 1'b0;
        #1;
        n_tests++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || halt !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_outputs got=%b/%h/%b/%b exp=0/00/0/0", tx_valid, tx_data, halt, done);
        end
        @(negedge clk);
        arstn = 1'b1;
        do_ecall(1'b0, 4'h0, 16'h0000, 16'h0000);
        for (int k = 0; k < 7; k++) begin
            n_tests++; if (tx_valid !== 1'b1 || tx_data !== req[k]) begin
                n_fail++; $display("FAIL midrst_b%0d got=%b/%h exp=1/%h", k, tx_valid, tx_data, req[k]);
            end
            @(negedge clk);
        end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL midrst_done got=%b exp=1", done); end
    endtask

    task automatic test_idle();
        apply_reset();
        for (int c = 0; c < 100; c++) begin
            a0 = 1'($urandom); cause = 4'($urandom);
            total = 16'($urandom); mispred = 16'($urandom);
            tx_ready = 1'($urandom);
            @(negedge clk);
            n_tests++; if (tx_valid !== 1'b0 || halt !== 1'b0 || done !== 1'b0) begin
                n_fail++; $display("FAIL idle_c%0d got=%b/%b/%b exp=0/0/0", c, tx_valid, halt, done);
            end
        end
    endtask

    task automatic test_random();
        logic        fa0;
        logic [3:0]  fc;
        logic [15:0] ft, fm;
        logic [7:0]  got [$];
        logic        prev_stall;
        logic [7:0]  prev_data;
        int          cyc;
        for (int r = 0; r < 50; r++) begin
            apply_reset();
            fa0 = 1'($urandom); fc = 4'($urandom);
            ft = 16'($urandom); fm = 16'($urandom);
            build_frame(fa0, fc, ft, fm);
            tx_ready = 1'($urandom);
            do_ecall(fa0, fc, ft, fm);
            got.delete();
            prev_stall = 1'b0; prev_data = 8'h00; cyc = 0;
            while (done !== 1'b1 && cyc < 200) begin
                if (prev_stall) begin
                    n_tests++; if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                        n_fail++; $display("FAIL rnd%0d_hold got=%b/%h exp=1/%h", r, tx_valid, tx_data, prev_data);
                    end
                end
                a0 = 1'($urandom); total = 16'($urandom); ecall = 1'($urandom);
                tx_ready = ($urandom_range(0, 2) != 0);
                if (tx_valid === 1'b1 && tx_ready) got.push_back(tx_data);
                prev_stall = (tx_valid === 1'b1) && !tx_ready;
                prev_data  = tx_data;
                @(negedge clk);
                cyc++;
            end
            ecall = 1'b0;
            n_tests++; if (done !== 1'b1 || got.size() != 7) begin
                n_fail++; $display("FAIL rnd%0d_count got=%0d done=%b exp=7 done=1", r, got.size(), done);
            end
            for (int k = 0; k < 7 && k < got.size(); k++) begin
                n_tests++; if (got[k] !== exp_frame[k]) begin
                    n_fail++; $display("FAIL rnd%0d_b%0d got=%h exp=%h", r, k, got[k], exp_frame[k]);
                end
            end
        end
        tx_ready = 1'b1;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        arstn = 1'b0; ecall = 1'b0; a0 = 1'b0; cause = '0;
        total = '0; mispred = '0; tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_isolation();
        test_reset_midframe();
        test_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ecall_status_tx.md
# ecall_status_tx

Captures end-of-test status when an `ecall` retires in write-back and transmits it to the host as a framed byte stream over a valid/ready interface. Snapshot contents: a0 LSB, trap cause, branch-total and branch-mispredict counters. This is the synthesizable transmit end of the write-back test-status check, for FPGA runs where simulation-only reporting is unavailable. It sits beside the write-back stage, is fed by the same signals, and drives a byte sink such as a UART or debug FIFO.

## Interface

Parameters:
- `CNT_W`, 16, width of each branch counter. Fixed at 16; the packet format depends on it.
- `HDR`, 8'hA5, frame header byte.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_arstn`  in  1  asynchronous active-low reset.
- `i_ecall_instr`  in  1  ecall retiring in write-back this cycle.
- `i_a0_reg_lsb`  in  1  LSB of a0 (test pass/fail).
- `i_cause`  in  4  mcause code.
- `i_branch_total`  in  CNT_W  retired branch count.
- `i_branch_mispred`  in  CNT_W  mispredicted branch count.
- `o_tx_data`  out  8  current byte.
- `o_tx_valid`  out  1  `o_tx_data` is valid.
- `i_tx_ready`  in  1  sink accepts the byte when high together with `o_tx_valid`.
- `o_halt`  out  1  pipeline freeze request; sticky.
- `o_done`  out  1  frame fully sent; sticky.

## Operation

Frame is 7 bytes, sent in index order 0..6:
- b0 = `HDR`.
- b1 = {3'b000, cause[3:0], a0_lsb}.
- b2 = branch_total[7:0]; b3 = branch_total[15:8].
- b4 = branch_mispred[7:0]; b5 = branch_mispred[15:8].
- b6 = b0^b1^b2^b3^b4^b5.

State machine: IDLE, SEND, DONE.
- IDLE, `i_ecall_instr`=1: register all inputs into the snapshot, set byte index to 0, set `o_halt`, go to SEND.
- IDLE, otherwise: stay.
- SEND: `o_tx_valid`=1 and `o_tx_data`=byte[index]. On `o_tx_valid & i_tx_ready`, index increments. If index was 6, go to DONE and set `o_done`.
- DONE: stay until reset. `o_tx_valid`=0.

Handshake rules:
- Once `o_tx_valid` rises it is never dropped before the byte is accepted.
- `o_tx_data` is stable while `o_tx_valid & !i_tx_ready`.

Snapshot and edge cases:
- The snapshot is frozen at capture. Input changes after capture never alter the frame.
- `i_ecall_instr` in SEND or DONE is ignored: no re-capture, no restart.
- Checksum is computed from snapshot registers, either at capture or incrementally. It must equal the XOR above.
- Reset at any time, including mid-frame, aborts the frame. The next ecall starts a fresh frame at b0.

## Timing

- Reset values: `o_tx_valid`=0, `o_tx_data`=0, `o_halt`=0, `o_done`=0, state IDLE, index 0, snapshot 0.
- Ecall sampled at edge N: `o_halt`=1 and `o_tx_valid`=1 with b0 from cycle N+1.
- With `i_tx_ready` tied high, b0..b6 are on the bus in cycles N+1..N+7. `o_done`=1 and `o_tx_valid`=0 from N+8.
- Each low cycle of `i_tx_ready` during SEND adds exactly one cycle.
- All outputs are registered, or derived only from state/index/snapshot registers. There is no combinational path from inputs to outputs.
- `o_halt` lags the ecall by one cycle. The pipeline tolerates this.

## Test plan

- Basic frame, ready high: ecall with a0=1, cause=4'hB, total=16'h1234, mispred=16'h0056. Required bytes: A5, 17, 34, 12, 56, 00, C2 in cycles N+1..N+7; `o_done` at N+8; `o_halt` high from N+1 onward.
- Backpressure: same frame, `i_tx_ready` low for 3 cycles while b2 is presented. `o_tx_data` holds 8'h34 with valid high; `o_done` at N+11; byte order unchanged.
- Snapshot isolation and duplicate ecall: after capture, drive total=16'hFFFF and pulse `i_ecall_instr` again during SEND and during DONE. Frame is unchanged (b2=34, b3=12), with no second frame and no restart.
- Reset mid-frame: assert `i_arstn`=0 asynchronously after b3 is accepted. All outputs go to 0 immediately. Then an ecall with a0=0, cause=0, total=0, mispred=0 yields A5, 00, 00, 00, 00, 00, A5.
- Idle quiet: 100 cycles with no ecall and random counter inputs. `o_tx_valid`, `o_halt` and `o_done` stay 0.
- Random ready with a scoreboard: 50 runs of random field values and random `i_tx_ready`. Each run yields exactly 7 accepted bytes matching the format, and the checksum matches.
